// File: rtl/snake_game_core.sv
// Sequential core of the 8x8 snake game: body, direction, food relocation,
// score and the IDLE/RUN/REFOOD/OVER state machine.
module snake_game_core #(
  parameter logic [5:0]  FOOD_SEED = 6'd45,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic               btn_valid,
  input  logic [1:0]         btn_dir,
  input  logic               eat,
  input  logic               hit_body,
  output logic [5:0]         idx_head_next,
  output logic [5:0]         idx0,
  output logic [5:0]         idx1,
  output logic [5:0]         idx2,
  output logic [5:0]         idx_food,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               running
);

  typedef enum logic [1:0] {IDLE, RUN, REFOOD, OVER} state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  state_t     state, state_nxt;
  logic [1:0] dir, last_dir;
  logic [5:0] lfsr, lfsr_nxt;
  logic [2:0] row, col;
  logic       wall_hit, food_hit, move, reload, dir_ok;

  assign row      = idx0[5:3];
  assign col      = idx0[2:0];
  assign lfsr_nxt = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
  assign food_hit = (lfsr == idx0) || (lfsr == idx1) || (lfsr == idx2);
  // Opposite directions differ only in bit 1.
  assign dir_ok   = (btn_dir != (last_dir ^ 2'b10));

  always_comb begin
    wall_hit      = 1'b0;
    idx_head_next = idx0;
    unique case (dir)
      DIR_UP:    begin wall_hit = (row == 3'd0); idx_head_next = idx0 - 6'd8; end
      DIR_RIGHT: begin wall_hit = (col == 3'd7); idx_head_next = idx0 + 6'd1; end
      DIR_DOWN:  begin wall_hit = (row == 3'd7); idx_head_next = idx0 + 6'd8; end
      DIR_LEFT:  begin wall_hit = (col == 3'd0); idx_head_next = idx0 - 6'd1; end
    endcase
  end

  always_comb begin
    state_nxt = state;
    move      = 1'b0;
    reload    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (tick) begin
          if (wall_hit || hit_body) begin
            state_nxt = OVER;
          end else begin
            move = 1'b1;
            if (eat) state_nxt = REFOOD;
          end
        end
      end
      REFOOD: if (!food_hit) state_nxt = RUN;
      OVER: begin
        if (start) begin
          reload    = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      idx0     <= 6'd26;
      idx1     <= 6'd25;
      idx2     <= 6'd24;
      dir      <= DIR_RIGHT;
      last_dir <= DIR_RIGHT;
      lfsr     <= FOOD_SEED;
      idx_food <= FOOD_SEED;
      score    <= '0;
    end else begin
      if (btn_valid && dir_ok) dir <= btn_dir;
      if (move) begin
        idx2     <= idx1;
        idx1     <= idx0;
        idx0     <= idx_head_next;
        last_dir <= dir;
        if (eat) begin
          if (score != {SCORE_W{1'b1}}) score <= score + 1'b1;
          lfsr <= lfsr_nxt;
        end
      end
      // Candidate is checked against the already-shifted body.
      if (state == REFOOD) begin
        if (food_hit) lfsr     <= lfsr_nxt;
        else          idx_food <= lfsr;
      end
    end
  end

  assign game_over = (state == OVER);
  assign running   = (state == RUN) || (state == REFOOD);

endmodule

// File: tb/tb_snake_game_core.sv
// Directed bench for snake_game_core; a second instance with SCORE_W=2
// shares the stimulus to exercise score saturation.
module tb_snake_game_core;
  logic       clk = 1'b0;
  logic       rst, start, tick, btn_valid, eat, hit_body;
  logic [1:0] btn_dir;
  logic [5:0] hn, i0, i1, i2, food;
  logic [7:0] score;
  logic       go, run;
  logic [5:0] s_hn, s_i0, s_i1, s_i2, s_food;
  logic [1:0] s_score;
  logic       s_go, s_run;
  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  snake_game_core u_dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .btn_valid(btn_valid),
    .btn_dir(btn_dir), .eat(eat), .hit_body(hit_body), .idx_head_next(hn),
    .idx0(i0), .idx1(i1), .idx2(i2), .idx_food(food), .score(score),
    .game_over(go), .running(run)
  );

  snake_game_core #(.FOOD_SEED(6'd45), .SCORE_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .btn_valid(btn_valid),
    .btn_dir(btn_dir), .eat(eat), .hit_body(hit_body), .idx_head_next(s_hn),
    .idx0(s_i0), .idx1(s_i1), .idx2(s_i2), .idx_food(s_food), .score(s_score),
    .game_over(s_go), .running(s_run)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_tick(input logic e, input logic h);
    tick = 1'b1; eat = e; hit_body = h;
    step();
    tick = 1'b0; eat = 1'b0; hit_body = 1'b0;
  endtask

  task automatic do_btn(input logic [1:0] d);
    btn_valid = 1'b1; btn_dir = d; step(); btn_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nchk++;
    if ({i0, i1, i2, food} !== {6'd26, 6'd25, 6'd24, 6'd45}) begin
      nerr++; $display("FAIL reset_cells got %0d/%0d/%0d food %0d exp 26/25/24 food 45", i0, i1, i2, food);
    end
    nchk++;
    if ({score, go, run, hn} !== {8'd0, 1'b0, 1'b0, 6'd27}) begin
      nerr++; $display("FAIL reset_flags got score %0d go %0b run %0b hn %0d exp 0 0 0 27", score, go, run, hn);
    end
    do_tick(1'b0, 1'b0);
    nchk++;
    if ({i0, run} !== {6'd26, 1'b0}) begin
      nerr++; $display("FAIL idle_tick got idx0 %0d run %0b exp 26 0", i0, run);
    end
    do_start();
    do_tick(1'b0, 1'b0);
    nchk++;
    if ({i0, i1, i2, hn, score, go, run} !== {6'd27, 6'd26, 6'd25, 6'd28, 8'd0, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL first_move got %0d/%0d/%0d hn %0d score %0d go %0b exp 27/26/25 hn 28 score 0 go 0", i0, i1, i2, hn, score, go);
    end
  endtask

  task automatic test_wall();
    do_reset(); do_start();
    for (int k = 0; k < 5; k++) do_tick(1'b0, 1'b0);
    nchk++;
    if ({i0, i1, i2, go} !== {6'd31, 6'd30, 6'd29, 1'b0}) begin
      nerr++; $display("FAIL wall_pre got %0d/%0d/%0d go %0b exp 31/30/29 0", i0, i1, i2, go);
    end
    do_tick(1'b1, 1'b0);
    nchk++;
    if ({go, run, i0, i1, i2, score} !== {1'b1, 1'b0, 6'd31, 6'd30, 6'd29, 8'd0}) begin
      nerr++; $display("FAIL wall_hit got go %0b run %0b %0d/%0d/%0d score %0d exp 1 0 31/30/29 0", go, run, i0, i1, i2, score);
    end
    do_tick(1'b0, 1'b0);
    nchk++;
    if ({go, i0, i1, i2} !== {1'b1, 6'd31, 6'd30, 6'd29}) begin
      nerr++; $display("FAIL over_hold got go %0b %0d/%0d/%0d exp 1 31/30/29", go, i0, i1, i2);
    end
  endtask

  task automatic test_eat();
    do_reset(); do_start();
    do_tick(1'b1, 1'b0);
    nchk++;
    if ({i0, score, run, food} !== {6'd27, 8'd1, 1'b1, 6'd45}) begin
      nerr++; $display("FAIL eat_edge1 got head %0d score %0d run %0b food %0d exp 27 1 1 45", i0, score, run, food);
    end
    do_tick(1'b1, 1'b1);
    nchk++;
    if ({i0, score, go, food} !== {6'd27, 8'd1, 1'b0, 6'd45}) begin
      nerr++; $display("FAIL eat_edge2 got head %0d score %0d go %0b food %0d exp 27 1 0 45", i0, score, go, food);
    end
    step();
    nchk++;
    if ({food, run, i0} !== {6'd55, 1'b1, 6'd27}) begin
      nerr++; $display("FAIL eat_edge3 got food %0d run %0b head %0d exp 55 1 27", food, run, i0);
    end
    step();
    nchk++;
    if (food !== 6'd55) begin
      nerr++; $display("FAIL eat_settle got food %0d exp 55", food);
    end
  endtask

  task automatic test_dir();
    do_reset(); do_start();
    do_btn(2'd3);
    nchk++;
    if (hn !== 6'd27) begin
      nerr++; $display("FAIL dir_reverse got hn %0d exp 27", hn);
    end
    do_btn(2'd0);
    do_btn(2'd2);
    nchk++;
    if (hn !== 6'd34) begin
      nerr++; $display("FAIL dir_down got hn %0d exp 34", hn);
    end
    do_tick(1'b0, 1'b0);
    nchk++;
    if ({i0, i1, i2} !== {6'd34, 6'd26, 6'd25}) begin
      nerr++; $display("FAIL dir_move got %0d/%0d/%0d exp 34/26/25", i0, i1, i2);
    end
    btn_valid = 1'b1; btn_dir = 2'd1;
    do_tick(1'b0, 1'b0);
    btn_valid = 1'b0;
    nchk++;
    if ({i0, hn} !== {6'd42, 6'd43}) begin
      nerr++; $display("FAIL dir_same_cycle got head %0d hn %0d exp 42 43", i0, hn);
    end
    do_btn(2'd0);
    nchk++;
    if (hn !== 6'd43) begin
      nerr++; $display("FAIL dir_last_reverse got hn %0d exp 43", hn);
    end
  endtask

  task automatic test_body_hit();
    do_reset(); do_start();
    do_tick(1'b1, 1'b0);
    step(); step();
    do_tick(1'b1, 1'b1);
    nchk++;
    if ({go, run, score, i0, i1, i2, food} !== {1'b1, 1'b0, 8'd1, 6'd27, 6'd26, 6'd25, 6'd55}) begin
      nerr++; $display("FAIL body_hit got go %0b run %0b score %0d %0d/%0d/%0d food %0d exp 1 0 1 27/26/25 55", go, run, score, i0, i1, i2, food);
    end
    do_btn(2'd2);
    nchk++;
    if (hn !== 6'd35) begin
      nerr++; $display("FAIL over_dir got hn %0d exp 35", hn);
    end
    do_start();
    nchk++;
    if ({i0, i1, i2, score, food, run, go, hn} !== {6'd26, 6'd25, 6'd24, 8'd0, 6'd45, 1'b1, 1'b0, 6'd27}) begin
      nerr++; $display("FAIL restart got %0d/%0d/%0d score %0d food %0d run %0b go %0b hn %0d exp 26/25/24 0 45 1 0 27", i0, i1, i2, score, food, run, go, hn);
    end
  endtask

  task automatic test_saturation();
    do_reset(); do_start();
    for (int k = 0; k < 4; k++) begin
      do_tick(1'b1, 1'b0);
      for (int j = 0; j < 4; j++) step();
    end
    nchk++;
    if ({s_score, score, s_i0} !== {2'd3, 8'd4, 6'd30}) begin
      nerr++; $display("FAIL saturate got sat %0d wide %0d head %0d exp 3 4 30", s_score, score, s_i0);
    end
    do_tick(1'b1, 1'b0);
    nchk++;
    if ({s_run, s_i0, s_score} !== {1'b1, 6'd31, 2'd3}) begin
      nerr++; $display("FAIL sat_refood got run %0b head %0d score %0d exp 1 31 3", s_run, s_i0, s_score);
    end
    do_reset();
    nchk++;
    if ({s_i0, s_i1, s_i2, s_food, s_score, s_go, s_run, s_hn} !== {6'd26, 6'd25, 6'd24, 6'd45, 2'd0, 1'b0, 1'b0, 6'd27}) begin
      nerr++; $display("FAIL refood_reset got %0d/%0d/%0d food %0d score %0d go %0b run %0b hn %0d exp 26/25/24 45 0 0 0 27", s_i0, s_i1, s_i2, s_food, s_score, s_go, s_run, s_hn);
    end
    nchk++;
    if ({i0, food, score, run} !== {6'd26, 6'd45, 8'd0, 1'b0}) begin
      nerr++; $display("FAIL refood_reset_wide got head %0d food %0d score %0d run %0b exp 26 45 0 0", i0, food, score, run);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; tick = 1'b0; btn_valid = 1'b0;
    btn_dir = 2'd0; eat = 1'b0; hit_body = 1'b0;
    test_reset();
    test_wall();
    test_eat();
    test_dir();
    test_body_hit();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
